base_wrr_arb: RTL and testbench

BASE_WRR_ARB -- requirements
Module: base_wrr_arb

---
 rtl/base_arb_pkg.sv | 28 ++
 rtl/base_rr_pick.sv | 33 +++
 rtl/base_wrr_arb.sv | 108 ++++++++++
 tb/tb_base_wrr_arb.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/base_arb_pkg.sv
// Shared constants and weight-field helper for the base weighted round-robin arbiter.
package base_arb_pkg;

  localparam int DEF_WAYS  = 4;
  localparam int DEF_WBITS = 3;
  localparam int MAX_WAYS  = 16;
  localparam int MAX_WBITS = 8;
  localparam int FLAT_W    = MAX_WAYS * MAX_WBITS;

  // cfg_flat is the numeric value of an ascending [0:ways*wbits-1] vector,
  // so way 0 sits in the most significant field.
  function automatic logic [MAX_WBITS-1:0] weight_field(
    input logic [FLAT_W-1:0] cfg_flat,
    input int                ways,
    input int                wbits,
    input int                k
  );
    logic [FLAT_W-1:0]    shifted;
    logic [MAX_WBITS-1:0] res;
    shifted = cfg_flat >> ((ways - 1 - k) * wbits);
    res = '0;
    for (int b = 0; b < MAX_WBITS; b++) begin
      if (b < wbits) res[b] = shifted[b];
    end
    return res;
  endfunction

endpackage

// File: rtl/base_rr_pick.sv
// Combinational rotating first-one finder: grant the first request at or after
// the one-hot pointer, wrapping around.
module base_rr_pick
  import base_arb_pkg::*;
#(
  parameter int WAYS = DEF_WAYS
) (
  input  logic [0:WAYS-1] req_i,
  input  logic [0:WAYS-1] ptr_i,
  output logic [0:WAYS-1] gnt_o
);

  always_comb begin
    int  start;
    int  idx;
    logic found;
    start = 0;
    idx   = 0;
    found = 1'b0;
    gnt_o = '0;
    for (int k = 0; k < WAYS; k++) begin
      if (ptr_i[k]) start = k;
    end
    for (int i = 0; i < WAYS; i++) begin
      idx = (start + i) % WAYS;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/base_wrr_arb.sv
// Zero-latency weighted round-robin arbiter with per-way quota and locked bursts.
module base_wrr_arb
  import base_arb_pkg::*;
#(
  parameter int ways  = DEF_WAYS,
  parameter int wbits = DEF_WBITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [0:ways-1]       i_v,
  input  logic [0:ways-1]       i_h,
  output logic [0:ways-1]       i_r,
  input  logic [0:ways*wbits-1] cfg_w,
  input  logic                  o_r,
  output logic                  o_v,
  output logic [0:ways-1]       o_s,
  output logic                  o_h
);

  localparam logic [0:ways-1] PTR_INIT = ways'(1) << (ways - 1);

  logic [0:ways-1]   owner_q, owner_d;
  logic [0:ways-1]   ptr_q, ptr_d;
  logic [wbits-1:0]  cnt_q, cnt_d;
  logic              lock_q, lock_d;

  logic [FLAT_W-1:0] cfg_flat;
  logic [wbits-1:0]  weight [ways];
  logic [0:ways-1]   owner_rot, sel_rot, search_ptr, pick, sel;
  logic [wbits-1:0]  pick_w, rem;
  logic              has_owner, owner_vld, keep, acc;

  assign cfg_flat = FLAT_W'(cfg_w);

  for (genvar gi = 0; gi < ways; gi++) begin : g_way
    assign weight[gi]    = wbits'(weight_field(cfg_flat, ways, wbits, gi));
    assign owner_rot[gi] = owner_q[(gi + ways - 1) % ways];
    assign sel_rot[gi]   = sel[(gi + ways - 1) % ways];
  end

  assign has_owner  = |owner_q;
  assign owner_vld  = |(owner_q & i_v);
  // An unlocked owner that went idle gives up the grant this very cycle.
  assign keep       = has_owner & (lock_q | owner_vld);
  assign search_ptr = has_owner ? owner_rot : ptr_q;

  base_rr_pick #(.WAYS(ways)) u_pick (
    .req_i (i_v),
    .ptr_i (search_ptr),
    .gnt_o (pick)
  );

  assign sel = keep ? owner_q : pick;
  assign o_v = keep ? owner_vld : |i_v;
  assign o_s = o_v ? sel : '0;
  assign o_h = |(o_s & i_h);
  assign i_r = o_s & {ways{o_r}};
  assign acc = o_v & o_r;

  always_comb begin
    pick_w = '0;
    for (int k = 0; k < ways; k++) begin
      if (pick[k]) pick_w = pick_w | weight[k];
    end
  end

  // rem = beats still owed to the grant after the one being accepted now.
  always_comb begin
    rem = '0;
    if (keep) begin
      if (cnt_q != '0) rem = cnt_q - wbits'(1);
    end else begin
      if (pick_w != '0) rem = pick_w - wbits'(1);
    end
  end

  always_comb begin
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    lock_d  = lock_q;
    if (acc) begin
      lock_d = o_h;
      cnt_d  = rem;
      if (rem == '0 && !o_h) begin
        owner_d = '0;
        ptr_d   = sel_rot;
      end else begin
        owner_d = sel;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q <= '0;
      ptr_q   <= PTR_INIT;
      cnt_q   <= '0;
      lock_q  <= 1'b0;
    end else begin
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      lock_q  <= lock_d;
    end
  end

endmodule

// File: tb/tb_base_wrr_arb.sv
// Directed bench for base_wrr_arb (ways=4, wbits=3); outputs sampled on the falling edge.
module tb_base_wrr_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic [0:3]  i_v, i_h, i_r, o_s;
  logic [0:11] cfg_w;
  logic        o_r, o_v, o_h;
  int          errors = 0;
  int          checks = 0;

  base_wrr_arb #(.ways(4), .wbits(3)) dut (
    .clk   (clk),
    .reset (reset),
    .i_v   (i_v),
    .i_h   (i_h),
    .i_r   (i_r),
    .cfg_w (cfg_w),
    .o_r   (o_r),
    .o_v   (o_v),
    .o_s   (o_s),
    .o_h   (o_h)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    i_v   = 4'b0000;
    i_h   = 4'b0000;
    o_r   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cfg_w = {3'd1, 3'd1, 3'd1, 3'd1};
    i_h   = 4'b0000;
    o_r   = 1'b1;
    i_v   = 4'b0110;
    @(negedge clk);
    checks++;
    if (o_s !== 4'b0100 || o_v !== 1'b1 || i_r !== 4'b0100) begin
      errors++;
      $display("FAIL reset_lowest: o_s=%b o_v=%b i_r=%b want 0100 1 0100", o_s, o_v, i_r);
    end
    i_v = 4'b0000;
    #1;
    checks++;
    if (o_s !== 4'b0000 || o_v !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: o_s=%b o_v=%b want 0000 0", o_s, o_v);
    end
    i_v = 4'b1011;
    o_r = 1'b0;
    #1;
    checks++;
    if (o_s !== 4'b1000 || i_r !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready_low: o_s=%b i_r=%b want 1000 0000", o_s, i_r);
    end
    tick();
  endtask

  task automatic test_rr();
    logic [0:3] exp_s [5] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
    do_reset();
    cfg_w = {3'd1, 3'd1, 3'd1, 3'd1};
    i_v   = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (o_s !== exp_s[c] || i_r !== exp_s[c] || o_v !== 1'b1) begin
        errors++;
        $display("FAIL rr cyc%0d: o_s=%b i_r=%b o_v=%b want %b", c, o_s, i_r, o_v, exp_s[c]);
      end
      tick();
    end
  endtask

  task automatic test_weighted();
    logic [0:3] exp_s [8] = '{4'b1000, 4'b1000, 4'b1000, 4'b0100,
                              4'b0010, 4'b0010, 4'b0001, 4'b1000};
    do_reset();
    cfg_w = {3'd3, 3'd1, 3'd2, 3'd1};
    i_v   = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (o_s !== exp_s[c]) begin
        errors++;
        $display("FAIL weighted cyc%0d: o_s=%b want %b", c, o_s, exp_s[c]);
      end
      tick();
    end
  endtask

  task automatic test_lock();
    logic [0:3] hv    [7] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
    logic [0:3] exp_s [7] = '{4'b1000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0010, 4'b1000};
    logic       exp_h [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    cfg_w = {3'd1, 3'd1, 3'd1, 3'd1};
    i_v   = 4'b1110;
    for (int c = 0; c < 7; c++) begin
      i_h = hv[c];
      @(negedge clk);
      checks++;
      if (o_s !== exp_s[c] || o_h !== exp_h[c]) begin
        errors++;
        $display("FAIL lock cyc%0d: o_s=%b o_h=%b want %b %b", c, o_s, o_h, exp_s[c], exp_h[c]);
      end
      tick();
    end
    i_h = 4'b0000;
  endtask

  task automatic test_drop();
    logic [0:3] iv    [8] = '{4'b1100, 4'b1100, 4'b0100, 4'b1100,
                              4'b1100, 4'b1100, 4'b1100, 4'b1100};
    logic [0:3] exp_s [8] = '{4'b1000, 4'b1000, 4'b0100, 4'b1000,
                              4'b1000, 4'b1000, 4'b1000, 4'b0100};
    do_reset();
    cfg_w = {3'd4, 3'd1, 3'd1, 3'd1};
    for (int c = 0; c < 8; c++) begin
      i_v = iv[c];
      @(negedge clk);
      checks++;
      if (o_s !== exp_s[c]) begin
        errors++;
        $display("FAIL drop cyc%0d: o_s=%b want %b", c, o_s, exp_s[c]);
      end
      tick();
    end
  endtask

  task automatic test_lock_gap();
    logic [0:3] iv     [9] = '{4'b0010, 4'b1101, 4'b1111, 4'b1111, 4'b1111,
                               4'b1111, 4'b1111, 4'b1111, 4'b1111};
    logic [0:3] hv     [9] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000,
                               4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic       rv     [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [0:3] exp_s  [9] = '{4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0010,
                               4'b0010, 4'b0010, 4'b0001, 4'b1000};
    logic       exp_v  [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [0:3] exp_ir [9] = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000,
                               4'b0000, 4'b0010, 4'b0001, 4'b1000};
    do_reset();
    cfg_w = {3'd1, 3'd1, 3'd1, 3'd1};
    for (int c = 0; c < 9; c++) begin
      i_v = iv[c];
      i_h = hv[c];
      o_r = rv[c];
      @(negedge clk);
      checks++;
      if (o_s !== exp_s[c] || o_v !== exp_v[c] || i_r !== exp_ir[c]) begin
        errors++;
        $display("FAIL lock_gap cyc%0d: o_s=%b o_v=%b i_r=%b want %b %b %b",
                 c, o_s, o_v, i_r, exp_s[c], exp_v[c], exp_ir[c]);
      end
      tick();
    end
    o_r = 1'b1;
    i_h = 4'b0000;
  endtask

  task automatic test_reset_mid();
    logic [0:3] exp_s [4] = '{4'b1000, 4'b1000, 4'b1000, 4'b0100};
    do_reset();
    cfg_w = {3'd3, 3'd1, 3'd2, 3'd1};
    i_v   = 4'b0001;
    i_h   = 4'b0001;
    @(negedge clk);
    checks++;
    if (o_s !== 4'b0001) begin
      errors++;
      $display("FAIL mid_lock_grab: o_s=%b want 0001", o_s);
    end
    tick();
    i_v = 4'b1111;
    @(negedge clk);
    checks++;
    if (o_s !== 4'b0001 || o_h !== 1'b1) begin
      errors++;
      $display("FAIL mid_lock_hold: o_s=%b o_h=%b want 0001 1", o_s, o_h);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (o_s !== 4'b1000 || o_v !== 1'b1 || i_r !== 4'b1000) begin
      errors++;
      $display("FAIL mid_reset_async: o_s=%b o_v=%b i_r=%b want 1000 1 1000", o_s, o_v, i_r);
    end
    i_h = 4'b0000;
    tick();
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (o_s !== exp_s[c]) begin
        errors++;
        $display("FAIL mid_restart cyc%0d: o_s=%b want %b", c, o_s, exp_s[c]);
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b0;
    i_v   = 4'b0000;
    i_h   = 4'b0000;
    o_r   = 1'b1;
    cfg_w = '0;
    test_reset();
    test_rr();
    test_weighted();
    test_lock();
    test_drop();
    test_lock_gap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
